// File: rtl/fnd_pkg.sv
// Shared definitions for the multiplexed seven-segment (FND) scan controller.
package fnd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHOW  = 2'd1,
        ST_BLANK = 2'd2
    } fnd_state_e;

    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam logic [7:0] COM_OFF = 8'hFF;

    // Active-low g..a patterns for hex digits 0-F.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic logic [6:0] seg_lookup(input logic [3:0] value);
        return SEG_TABLE[value];
    endfunction

endpackage

// File: rtl/fnd_seg_dec.sv
// Hex value plus decimal-point request to an active-low segment byte {dp, g..a}.
module fnd_seg_dec
    import fnd_pkg::*;
(
    input  logic [3:0] value,
    input  logic       dp,
    output logic [7:0] seg
);

    assign seg = {~dp, seg_lookup(value)};

endmodule

// File: rtl/fnd_scan_ctrl.sv
// Time-multiplexed scan of up to eight FND digits with blanking gaps between digits.
// Optional leading-zero suppression is built when FND_LZ_SUPPRESS_EN is defined.
module fnd_scan_ctrl
    import fnd_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 100000,
    parameter int BLANK_CYC  = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [31:0] digit_val,
    input  logic [7:0]  dp_mask,
    input  logic [7:0]  blank_mask,
    output logic [7:0]  fnd_com,
    output logic [7:0]  fnd_data,
    output logic        frame_done
);

    localparam int MAX_CNT = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
    localparam int CW      = $clog2(MAX_CNT);
    localparam logic [CW-1:0] SHOW_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
    localparam logic [2:0]    LAST_IDX   = 3'(NUM_DIGITS - 1);

    fnd_state_e    state;
    logic [2:0]    idx;
    logic [CW-1:0] cnt;
    logic [31:0]   buf_val;
    logic [7:0]    buf_dp;
    logic [7:0]    buf_blank;
    logic [3:0]    cur_val;
    logic [7:0]    dec_seg;
    logic [7:0]    shown_data;

    // The frame buffer is only reloaded when a frame starts at digit 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            idx       <= '0;
            cnt       <= '0;
            buf_val   <= '0;
            buf_dp    <= '0;
            buf_blank <= '0;
        end else if (!en) begin
            state <= ST_IDLE;
            idx   <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state     <= ST_SHOW;
                    idx       <= '0;
                    cnt       <= '0;
                    buf_val   <= digit_val;
                    buf_dp    <= dp_mask;
                    buf_blank <= blank_mask;
                end
                ST_SHOW: begin
                    if (cnt == SHOW_LAST) begin
                        state <= ST_BLANK;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_BLANK: begin
                    if (cnt == BLANK_LAST) begin
                        state <= ST_SHOW;
                        cnt   <= '0;
                        if (idx == LAST_IDX) begin
                            idx       <= '0;
                            buf_val   <= digit_val;
                            buf_dp    <= dp_mask;
                            buf_blank <= blank_mask;
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign cur_val = buf_val[{idx, 2'b00} +: 4];

    fnd_seg_dec u_seg_dec (
        .value (cur_val),
        .dp    (buf_dp[idx]),
        .seg   (dec_seg)
    );

`ifdef FND_LZ_SUPPRESS_EN
    logic [2:0] lead_idx;

    always_comb begin
        lead_idx = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (buf_val[4*k +: 4] != 4'd0) lead_idx = 3'(k);
        end
    end

    always_comb begin
        shown_data = dec_seg;
        if (idx > lead_idx) shown_data = buf_dp[idx] ? 8'h7F : SEG_OFF;
        if (buf_blank[idx]) shown_data = SEG_OFF;
    end
`else
    always_comb begin
        shown_data = dec_seg;
        if (buf_blank[idx]) shown_data = SEG_OFF;
    end
`endif

    // Outputs trail the state by one cycle, so the first lit cycle follows the IDLE->SHOW edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fnd_com    <= COM_OFF;
            fnd_data   <= SEG_OFF;
            frame_done <= 1'b0;
        end else begin
            fnd_com    <= (en && state == ST_SHOW) ? ~(8'h01 << idx) : COM_OFF;
            fnd_data   <= (en && state == ST_SHOW) ? shown_data : SEG_OFF;
            frame_done <= en && state == ST_BLANK && cnt == '0 && idx == LAST_IDX;
        end
    end

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Scoreboard bench for fnd_scan_ctrl: a 4-digit and an 8-digit instance share the same stimulus.
module tb_fnd_scan_ctrl;

    localparam int SD  = 4;
    localparam int BC  = 2;
    localparam int DP_ = SD + BC;

    typedef struct {
        logic [31:0] v;
        logic [7:0]  dp;
        logic [7:0]  bl;
    } vec_t;

    typedef struct packed {
        logic [7:0] com4;
        logic [7:0] data4;
        logic       fd4;
        logic [7:0] com8;
        logic [7:0] data8;
        logic       fd8;
        logic       chk8;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [31:0] digit_val;
    logic [7:0]  dp_mask;
    logic [7:0]  blank_mask;
    logic [7:0]  com4, data4, com8, data8;
    logic        fd4, fd8;

    int total = 0;
    int bad   = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    fnd_scan_ctrl #(.NUM_DIGITS(4), .SCAN_DIV(SD), .BLANK_CYC(BC)) dut4 (
        .clk(clk), .rst(rst), .en(en), .digit_val(digit_val), .dp_mask(dp_mask),
        .blank_mask(blank_mask), .fnd_com(com4), .fnd_data(data4), .frame_done(fd4)
    );

    fnd_scan_ctrl #(.NUM_DIGITS(8), .SCAN_DIV(SD), .BLANK_CYC(BC)) dut8 (
        .clk(clk), .rst(rst), .en(en), .digit_val(digit_val), .dp_mask(dp_mask),
        .blank_mask(blank_mask), .fnd_com(com8), .fnd_data(data8), .frame_done(fd8)
    );

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    function automatic logic [7:0] digit_seg(input logic [31:0] v, input logic [7:0] dp,
                                             input logic [7:0] bl, input int k, input int nd);
        logic [3:0] nib;
        int hi;
        nib = 4'((v >> (4 * k)) & 32'hF);
        hi = 0;
        for (int j = 0; j < nd; j++) if (((v >> (4 * j)) & 32'hF) != 0) hi = j;
        if (bl[k]) return 8'hFF;
`ifdef FND_LZ_SUPPRESS_EN
        if (k > hi) return dp[k] ? 8'h7F : 8'hFF;
`endif
        return {~dp[k], seg7(nib)};
    endfunction

    // Expected {com, data, frame_done} t samples after the enabling edge.
    function automatic logic [16:0] model(input int t, input int nd, input logic [31:0] v,
                                          input logic [7:0] dp, input logic [7:0] bl);
        int u, r, k;
        logic [7:0] one;
        one = 8'h01;
        if (t == 0) return {8'hFF, 8'hFF, 1'b0};
        u = t - 1;
        r = u % DP_;
        k = (u % (nd * DP_)) / DP_;
        if (r < SD) return {~(one << k), digit_seg(v, dp, bl, k, nd), 1'b0};
        return {8'hFF, 8'hFF, (r == SD && k == nd - 1)};
    endfunction

    task automatic pushRun(input int n, input vec_t a, input vec_t b, input int chg_frame,
                           input logic chk8);
        exp_t e;
        vec_t s;
        for (int t = 0; t < n; t++) begin
            s = (t > 0 && (t - 1) / (4 * DP_) >= chg_frame) ? b : a;
            {e.com4, e.data4, e.fd4} = model(t, 4, s.v, s.dp, s.bl);
            {e.com8, e.data8, e.fd8} = model(t, 8, a.v, a.dp, a.bl);
            e.chk8 = chk8;
            q.push_back(e);
        end
    endtask

    task automatic pushDark(input int n);
        exp_t e;
        e = '{com4: 8'hFF, data4: 8'hFF, fd4: 1'b0, com8: 8'hFF, data8: 8'hFF, fd8: 1'b0,
              chk8: 1'b1};
        for (int i = 0; i < n; i++) q.push_back(e);
    endtask

    task automatic checkOutput(input string name, input exp_t e);
        total++;
        if ({com4, data4, fd4} !== {e.com4, e.data4, e.fd4}) begin
            bad++;
            $display("[TB] FAIL %s (4-digit) @%0t: got com=%h data=%h fd=%b, want com=%h data=%h fd=%b",
                     name, $time, com4, data4, fd4, e.com4, e.data4, e.fd4);
        end
        if (e.chk8) begin
            total++;
            if ({com8, data8, fd8} !== {e.com8, e.data8, e.fd8}) begin
                bad++;
                $display("[TB] FAIL %s (8-digit) @%0t: got com=%h data=%h fd=%b, want com=%h data=%h fd=%b",
                         name, $time, com8, data8, fd8, e.com8, e.data8, e.fd8);
            end
        end
    endtask

    task automatic runCycles(input int n, input string name);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL %s: scoreboard empty at %0t", name, $time);
            end else begin
                e = q.pop_front();
                checkOutput(name, e);
            end
        end
    endtask

    task automatic applyStimulus(input vec_t s, input logic en_val);
        digit_val  = s.v;
        dp_mask    = s.dp;
        blank_mask = s.bl;
        en         = en_val;
    endtask

    // Hold reset over one edge, then release it together with en high.
    task automatic restart(input vec_t s);
        @(negedge clk);
        rst = 1'b0;
        en  = 1'b0;
        @(negedge clk);
        applyStimulus(s, 1'b1);
        rst = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vec_t vecs[5];
        vec_t base, nines;
        exp_t dark;

        vecs[0] = '{v: 32'h0000_4321, dp: 8'h00, bl: 8'h00};
        vecs[1] = '{v: 32'h0000_CAFE, dp: 8'h0A, bl: 8'h00};
        vecs[2] = '{v: 32'h0000_4321, dp: 8'h01, bl: 8'h02};
        vecs[3] = '{v: 32'h0000_0050, dp: 8'h00, bl: 8'h00};
        vecs[4] = '{v: 32'h8765_B0D9, dp: 8'h81, bl: 8'h10};
        base    = vecs[0];
        nines   = '{v: 32'h0000_9999, dp: 8'h00, bl: 8'h00};
        dark    = '{com4: 8'hFF, data4: 8'hFF, fd4: 1'b0, com8: 8'hFF, data8: 8'hFF, fd8: 1'b0,
                    chk8: 1'b1};

        rst = 1'b0;
        applyStimulus(base, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_state", dark);

        for (int i = 0; i < 5; i++) begin
            restart(vecs[i]);
            pushRun(50, vecs[i], vecs[i], 99, 1'b1);
            runCycles(50, $sformatf("vector%0d", i));
        end

        // New digit values arrive while digit 2 is lit; they appear from the next frame only.
        restart(base);
        pushRun(50, base, nines, 1, 1'b0);
        runCycles(15, "midframe_old");
        applyStimulus(nines, 1'b1);
        runCycles(35, "midframe_new");

        restart(base);
        pushRun(4, base, base, 99, 1'b1);
        runCycles(4, "en_drop_pre");
        en = 1'b0;
        pushDark(3);
        runCycles(3, "en_drop_dark");
        en = 1'b1;
        pushRun(10, base, base, 99, 1'b1);
        runCycles(10, "en_restart");

        restart(base);
        pushRun(12, base, base, 99, 1'b1);
        runCycles(12, "rst_pulse_pre");
        #2;
        rst = 1'b0;
        #1;
        checkOutput("rst_async_dark", dark);
        restart(base);
        pushRun(10, base, base, 99, 1'b1);
        runCycles(10, "rst_restart");

        if (q.size() != 0) begin
            total++;
            bad++;
            $display("[TB] FAIL scoreboard_leftover: got %0d entries, want 0", q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
